dti_fifo_async_wr_status: RTL and testbench
===========================================

DTI_FIFO_ASYNC_WR_STATUS -- requirements
Module: dti_fifo_async_wr_status

Interface
- REQ-001: The block SHALL have parameter ADDR_WIDTH, default 4, which sets the memory address width (depth = 2**ADDR_WIDTH); legal range is 2 or more.
- REQ-002: The block SHALL have parameter SYNC_STAGES, default 2, which sets the number of flops in the read-pointer synchronizer; legal range is 2 or more.
- REQ-003: The block SHALL have parameter AFULL_THRESH, default 2**ADDR_WIDTH-2, which is the fill level at which wr_afull asserts.
- REQ-004: The block SHALL have a clock named clk: input, 1 bit, write-domain rising-edge clock.
- REQ-005: The block SHALL have a reset named reset_n: input, 1 bit, asynchronous, active-low.
- REQ-006: wr_req SHALL be an input, 1 bit: the upstream write request.
- REQ-007: wr_en SHALL be an output, 1 bit: the qualified write; it drives the write pointer generator's incr_ptr and the memory write enable.
- REQ-008: wr_gray_ptr_nx SHALL be an input, ADDR_WIDTH+1 bits: the next gray write pointer from the pointer generator.
- REQ-009: wr_bin_ptr_nx SHALL be an input, ADDR_WIDTH+1 bits: the next binary write pointer from the pointer generator.
- REQ-010: rd_gray_ptr SHALL be an input, ADDR_WIDTH+1 bits: the registered gray read pointer, launched from the read clock domain.
- REQ-011: wr_full SHALL be an output, 1 bit: the registered full flag.
- REQ-012: wr_afull SHALL be an output, 1 bit: the registered almost-full flag.
- REQ-013: wr_level SHALL be an output, ADDR_WIDTH+1 bits: the registered fill level seen from the write domain.
- REQ-014: wr_overflow SHALL be an output, 1 bit: a one-cycle pulse that marks a write attempted while full.

Function
- REQ-015: wr_en SHALL equal wr_req AND NOT wr_full, combinationally, with no added latency.
- REQ-016: rd_gray_ptr SHALL pass through SYNC_STAGES flops clocked by clk; the output of the last stage is rq_sync.
- REQ-017: full_nx SHALL be true when wr_gray_ptr_nx equals rq_sync with its two MSBs inverted and all other bits unchanged.
- REQ-018: wr_full SHALL load full_nx on every clk edge.
- REQ-019: The full flag timing SHALL be as follows:
  - wr_full asserts on the same edge that stores the last free location.
  - wr_full deasserts SYNC_STAGES+1 clk edges after the read pointer advances (pessimistic release).
- REQ-020: level_nx SHALL be computed as wr_bin_ptr_nx minus gray_to_bin(rq_sync), modulo 2**(ADDR_WIDTH+1); the range is 0 to 2**ADDR_WIDTH.
- REQ-021: wr_level SHALL load level_nx every cycle.
- REQ-022: wr_afull SHALL load (level_nx >= AFULL_THRESH) every cycle.
- REQ-023: wr_overflow SHALL load (wr_req AND wr_full) every cycle; the pointer SHALL NOT advance on an overflowing request.
- REQ-024: Pointer wrap-around SHALL be handled by the extra MSB, with no special-case logic.
- REQ-025: If wr_req and a read-pointer change occur in the same cycle, the write SHALL be evaluated against the stale rq_sync; the result is conservative and never overflows the memory.

Reset
- REQ-026: When reset_n is low, every synchronizer flop SHALL be 0, and wr_full, wr_afull, wr_level and wr_overflow SHALL all be 0.
- REQ-027: Reset asserted mid-operation SHALL clear all state immediately; the read domain and the pointer generators SHALL be reset together.
- REQ-028: On reset release, wr_en SHALL follow wr_req on the first cycle.

Configuration
- REQ-029: With macro DTI_FIFO_ASYNC_WR_STATUS_LEVEL_EN defined, the gray-to-binary conversion, subtractor, wr_level register and wr_afull register SHALL be compiled in.
- REQ-030: With DTI_FIFO_ASYNC_WR_STATUS_LEVEL_EN undefined, wr_level and wr_afull SHALL be tied to 0 and no level logic SHALL be built; all other behaviour SHALL be unchanged.

Structure
- REQ-031: The FIFO package SHALL hold the depth/threshold constant helpers and the gray-to-binary function, shared with the read-side empty block.
- REQ-032: The block SHALL contain one sub-module: dti_sync_nff, a SYNC_STAGES-deep multi-bit synchronizer with asynchronous reset, reused by the read side.

Verification
Each scenario uses ADDR_WIDTH=4 (depth 16) and AFULL_THRESH=14.
- REQ-033: Scenario 1 (reset): Hold reset_n low with wr_req=1 and random rd_gray_ptr -> all outputs are 0; wr_en=1 after release.
- REQ-034: Scenario 2 (fill to full): Apply 16 consecutive wr_req with no reads -> wr_afull is 1 after the 14th write; wr_full is 1 on the edge of the 16th write; wr_level=16; a 17th request gives wr_en=0 and a one-cycle wr_overflow.
- REQ-035: Scenario 3 (release latency): Starting full, advance rd_gray_ptr by one -> wr_full stays 1 for exactly 2 edges, then goes 0; wr_level=15.
- REQ-036: Scenario 4 (wrap-around): Write and read 40 entries with the level held between 3 and 5 -> wr_full is never set and wr_level stays correct across pointer wrap 31->0.
- REQ-037: Scenario 5 (simultaneous events): At level 15, drive a write and a read-pointer advance on the same cycle -> wr_full asserts; it deasserts after the sync delay; no overflow occurs.
- REQ-038: Scenario 6 (level feature off): Build without DTI_FIFO_ASYNC_WR_STATUS_LEVEL_EN and rerun scenario 2 -> wr_level and wr_afull stay 0; full and overflow timing is identical to scenario 2.

Source files
------------

// File: rtl/dti_fifo_async_wr_status_pkg.sv
// Shared async-FIFO helpers: depth/threshold constants and gray-to-binary conversion,
// used by both the write-side full block and the read-side empty block.
package dti_fifo_async_wr_status_pkg;

  localparam int DEFAULT_ADDR_WIDTH  = 4;
  localparam int DEFAULT_SYNC_STAGES = 2;

  function automatic int fifo_depth(input int addr_width);
    return 2 ** addr_width;
  endfunction

  function automatic int afull_thresh_default(input int addr_width);
    return fifo_depth(addr_width) - 2;
  endfunction

  // Zero-extended inputs convert correctly; callers keep the low ADDR_WIDTH+1 bits.
  function automatic logic [31:0] gray_to_bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin[31] = gray[31];
    for (int i = 30; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/dti_fifo_async_wr_status_sync.sv
// Multi-bit flop-chain synchronizer (dti_sync_nff) with asynchronous active-low reset.
// Input must be gray coded so that at most one bit changes per source-clock update.
module dti_sync_nff #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/dti_fifo_async_wr_status.sv
// Write-side status of an async FIFO: synchronized read pointer, full/overflow flags and,
// when DTI_FIFO_ASYNC_WR_STATUS_LEVEL_EN is defined, the fill level and almost-full flag.
module dti_fifo_async_wr_status
  import dti_fifo_async_wr_status_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEFAULT_ADDR_WIDTH,
  parameter int SYNC_STAGES  = DEFAULT_SYNC_STAGES,
  parameter int AFULL_THRESH = afull_thresh_default(ADDR_WIDTH)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                wr_req,
  output logic                wr_en,
  input  logic [ADDR_WIDTH:0] wr_gray_ptr_nx,
  input  logic [ADDR_WIDTH:0] wr_bin_ptr_nx,
  input  logic [ADDR_WIDTH:0] rd_gray_ptr,
  output logic                wr_full,
  output logic                wr_afull,
  output logic [ADDR_WIDTH:0] wr_level,
  output logic                wr_overflow
);

  logic [ADDR_WIDTH:0] rq_sync;
  logic                full_d;
  logic                full_q;
  logic                overflow_d;
  logic                overflow_q;

  dti_sync_nff #(
    .WIDTH  (ADDR_WIDTH + 1),
    .STAGES (SYNC_STAGES)
  ) u_rd_ptr_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (rd_gray_ptr),
    .q_o     (rq_sync)
  );

  assign wr_en = wr_req & ~full_q;

  // Full when the next write pointer has lapped the (stale) read pointer by one full depth.
  assign full_d = (wr_gray_ptr_nx ==
                   {~rq_sync[ADDR_WIDTH:ADDR_WIDTH-1], rq_sync[ADDR_WIDTH-2:0]});
  assign overflow_d = wr_req & full_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end

  assign wr_full     = full_q;
  assign wr_overflow = overflow_q;

`ifdef DTI_FIFO_ASYNC_WR_STATUS_LEVEL_EN
  localparam logic [ADDR_WIDTH:0] AFULL_LVL = (ADDR_WIDTH + 1)'(AFULL_THRESH);

  logic [ADDR_WIDTH:0] rq_bin;
  logic [ADDR_WIDTH:0] level_d;
  logic [ADDR_WIDTH:0] level_q;
  logic                afull_d;
  logic                afull_q;

  assign rq_bin  = (ADDR_WIDTH + 1)'(gray_to_bin(32'(rq_sync)));
  assign level_d = wr_bin_ptr_nx - rq_bin;
  assign afull_d = (level_d >= AFULL_LVL);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= '0;
      afull_q <= 1'b0;
    end else begin
      level_q <= level_d;
      afull_q <= afull_d;
    end
  end

  assign wr_level = level_q;
  assign wr_afull = afull_q;
`else
  logic unused_bin_ptr;

  assign unused_bin_ptr = ^wr_bin_ptr_nx;
  assign wr_level       = '0;
  assign wr_afull       = 1'b0;
`endif

endmodule

// File: tb/tb_dti_fifo_async_wr_status.sv
// Bench for dti_fifo_async_wr_status (ADDR_WIDTH=4, SYNC_STAGES=2, AFULL_THRESH=14):
// directed vectors checked against a count-based occupancy model every cycle.
module tb_dti_fifo_async_wr_status;

  localparam int AW  = 4;
  localparam int SS  = 2;
  localparam int THR = 14;
  localparam int DEPTH = 1 << AW;
  localparam int MOD = 1 << (AW + 1);
`ifdef DTI_FIFO_ASYNC_WR_STATUS_LEVEL_EN
  localparam bit LEVEL_ON = 1'b1;
`else
  localparam bit LEVEL_ON = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          wr_req = 1'b0;
  logic          wr_en;
  logic [AW:0]   wr_gray_ptr_nx;
  logic [AW:0]   wr_bin_ptr_nx;
  logic [AW:0]   rd_gray_ptr = '0;
  logic          wr_full;
  logic          wr_afull;
  logic [AW:0]   wr_level;
  logic          wr_overflow;
  logic [AW:0]   pg_bin_q;

  always #5 clk = ~clk;

  dti_fifo_async_wr_status #(
    .ADDR_WIDTH   (AW),
    .SYNC_STAGES  (SS),
    .AFULL_THRESH (THR)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .wr_req         (wr_req),
    .wr_en          (wr_en),
    .wr_gray_ptr_nx (wr_gray_ptr_nx),
    .wr_bin_ptr_nx  (wr_bin_ptr_nx),
    .rd_gray_ptr    (rd_gray_ptr),
    .wr_full        (wr_full),
    .wr_afull       (wr_afull),
    .wr_level       (wr_level),
    .wr_overflow    (wr_overflow)
  );

  // Write pointer generator of the surrounding FIFO, reset together with the DUT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pg_bin_q <= '0;
    else if (wr_en) pg_bin_q <= pg_bin_q + 1'b1;
  end
  assign wr_bin_ptr_nx  = pg_bin_q + {{AW{1'b0}}, wr_en};
  assign wr_gray_ptr_nx = wr_bin_ptr_nx ^ (wr_bin_ptr_nx >> 1);

  // ---------------- occupancy model ----------------
  int rd_cnt;
  int m_wcnt;
  int m_hist[$];
  int m_level;
  bit m_full, m_afull, m_ovf;
  int n_vec = 0;
  int n_err = 0;

  function automatic logic [AW:0] to_gray(input int c);
    logic [AW:0] b;
    b = c[AW:0];
    return b ^ (b >> 1);
  endfunction

  task automatic set_rd(input int c);
    rd_cnt      = c;
    rd_gray_ptr = to_gray(c);
  endtask

  task automatic model_reset();
    m_wcnt = 0;
    m_hist = {};
    for (int i = 0; i < SS; i++) m_hist.push_back(0);
    m_level = 0;
    m_full  = 1'b0;
    m_afull = 1'b0;
    m_ovf   = 1'b0;
  endtask

  // Write side sees the read count from SS edges ago; occupancy is a plain difference.
  task automatic model_edge();
    int stale;
    int diff;
    stale = m_hist.pop_front();
    m_ovf = wr_req && m_full;
    if (wr_req && !m_full) m_wcnt++;
    diff    = (((m_wcnt - stale) % MOD) + MOD) % MOD;
    m_level = diff;
    m_full  = (diff == DEPTH);
    m_afull = (diff >= THR);
    m_hist.push_back(rd_cnt);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic compare_all();
    check("wr_en",       32'(wr_en),       32'(wr_req && !m_full));
    check("wr_full",     32'(wr_full),     32'(m_full));
    check("wr_overflow", 32'(wr_overflow), 32'(m_ovf));
    check("wr_level",    32'(wr_level),    LEVEL_ON ? 32'(m_level) : 32'd0);
    check("wr_afull",    32'(wr_afull),    LEVEL_ON ? 32'(m_afull) : 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_full"},  32'(wr_full),     32'd0);
    check({tag, "_afull"}, 32'(wr_afull),    32'd0);
    check({tag, "_level"}, 32'(wr_level),    32'd0);
    check({tag, "_ovf"},   32'(wr_overflow), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    model_reset();
    set_rd(0);

    // Reset held with a write request and a wandering read pointer.
    reset_n = 1'b0;
    wr_req  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rd_gray_ptr = 5'($urandom_range(0, MOD - 1));
      #1;
      check_all_zero("rst");
    end
    set_rd(0);
    model_reset();
    reset_n = 1'b1;
    #1;
    check("rel_wr_en", 32'(wr_en), 32'd1);

    // Fill to full: the held request is the first of sixteen writes.
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 13) check("fill_afull_13", 32'(wr_afull), 32'd0);
      if (i == 14) check("fill_afull_14", 32'(wr_afull), LEVEL_ON ? 32'd1 : 32'd0);
      if (i == 15) check("fill_full_15",  32'(wr_full),  32'd0);
    end
    check("fill_full_16",  32'(wr_full),  32'd1);
    check("fill_level_16", 32'(wr_level), LEVEL_ON ? 32'd16 : 32'd0);
    check("ovf_wr_en",     32'(wr_en),    32'd0);
    step();
    check("ovf_pulse",     32'(wr_overflow), 32'd1);
    wr_req = 1'b0;
    step();
    check("ovf_end",       32'(wr_overflow), 32'd0);
    check("ovf_still_full", 32'(wr_full),    32'd1);

    // Release latency: one read, two edges still full, third edge clear.
    set_rd(1);
    step();
    check("rel_full_e1", 32'(wr_full), 32'd1);
    step();
    check("rel_full_e2", 32'(wr_full), 32'd1);
    step();
    check("rel_full_e3", 32'(wr_full), 32'd0);
    check("rel_level",   32'(wr_level), LEVEL_ON ? 32'd15 : 32'd0);

    // Write and read on the same cycle at level 15.
    wr_req = 1'b1;
    set_rd(2);
    step();
    check("sim_full_e1", 32'(wr_full), 32'd1);
    wr_req = 1'b0;
    step();
    check("sim_full_e2", 32'(wr_full), 32'd1);
    step();
    check("sim_full_e3", 32'(wr_full), 32'd0);
    check("sim_no_ovf",  32'(wr_overflow), 32'd0);
    check("sim_level",   32'(wr_level), LEVEL_ON ? 32'd15 : 32'd0);

    // Mid-operation reset clears state without a clock edge.
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    model_reset();
    set_rd(0);
    wr_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Streaming across the pointer wrap: 40 writes, 40 reads, small occupancy.
    for (int cyc = 0; cyc < 60; cyc++) begin
      wr_req = (m_wcnt < 40);
      if ((m_wcnt >= 40 && rd_cnt < m_wcnt) || (rd_cnt < m_wcnt - 2)) set_rd(rd_cnt + 1);
      step();
      if (cyc > 4 && cyc < 36) begin
        check("wrap_level_band", 32'(LEVEL_ON ? (wr_level >= 3 && wr_level <= 5) : 1'b1), 32'd1);
      end
    end
    check("wrap_writes",  32'(m_wcnt), 32'd40);
    check("wrap_reads",   32'(rd_cnt), 32'd40);
    check("wrap_no_full", 32'(wr_full), 32'd0);
    check("wrap_level_0", 32'(wr_level), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
